// File: rtl/softmax_pkg.sv
// Shared types and width helpers for the pseudo-softmax engine.
package softmax_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SUM, NORM, EMIT} state_t;

    // Accumulator width: N terms of at most 2^FRAC each never overflow this.
    function automatic int sum_width(input int frac, input int n);
        return frac + 1 + $clog2(n);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    localparam int EXP_MAX = exp_max(3);

endpackage

// File: rtl/softmax_lod.sv
// Leading-one detector: position of the top set bit and the MANT_W bits just below it.
module softmax_lod #(
    parameter int W      = 11,
    parameter int MANT_W = 3
) (
    input  logic [W-1:0]         value,
    output logic [$clog2(W)-1:0] pos,
    output logic [MANT_W-1:0]    below
);
    localparam int PW = $clog2(W);

    // Padding below the LSB keeps the fraction defined when the leading one sits low.
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) pos = PW'(i);
        end
        below = MANT_W'({value, {MANT_W{1'b0}}} >> pos);
    end

endmodule

// File: rtl/pseudo_softmax_seq.sv
// Sequential base-2 pseudo-softmax over frames of N scores (Mitchell log/antilog).
// Define SOFTMAX_ARGMAX_EN to add the out_argmax / out_argmax_hit ports.
module pseudo_softmax_seq
    import softmax_pkg::*;
#(
    parameter int N      = 4,
    parameter int WIDTH  = 3,
    parameter int FRAC   = 8,
    parameter int MANT_W = 3,
    parameter int EXP_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_last
`ifdef SOFTMAX_ARGMAX_EN
    ,
    output logic [idx_width(N)-1:0] out_argmax,
    output logic                    out_argmax_hit
`endif
);
    localparam int SW   = sum_width(FRAC, N);
    localparam int IW   = idx_width(N);
    localparam int PW   = $clog2(SW);
    localparam int EMAX = exp_max(EXP_W);
    localparam logic [SW-1:0] ONE = SW'(1) << FRAC;

    state_t             state;
    logic [WIDTH-1:0]   buffer [N];
    logic [WIDTH-1:0]   max_val;
    logic [IW-1:0]      load_idx, sum_idx, emit_idx;
    logic [SW-1:0]      sum;
    logic [PW-1:0]      lod_pos, k_reg;
    logic [MANT_W-1:0]  lod_below, f_reg;
    logic [WIDTH-1:0]   emit_d;
    logic [SW-1:0]      emit_t;
    logic [EXP_W-1:0]   res_exp;
    logic [MANT_W-1:0]  res_mant;
    int                 e_full;
`ifdef SOFTMAX_ARGMAX_EN
    logic [IW-1:0]      max_idx;
`endif

    // 2^(-d) in Q1.FRAC; distances beyond FRAC underflow to zero.
    function automatic logic [SW-1:0] term(input logic [WIDTH-1:0] d);
        if (int'(d) > FRAC) return '0;
        return ONE >> d;
    endfunction

    softmax_lod #(.W(SW), .MANT_W(MANT_W)) u_lod (
        .value (sum),
        .pos   (lod_pos),
        .below (lod_below)
    );

    // Antilog of the current element: a nonzero f borrows one octave so the mantissa is 2^MANT_W - f.
    always_comb begin
        emit_d   = max_val - buffer[emit_idx];
        emit_t   = term(emit_d);
        e_full   = int'(emit_d) + int'(k_reg) + ((f_reg != '0) ? 1 : 0);
        res_exp  = EXP_W'(EMAX);
        res_mant = '0;
        if (emit_t != '0 && e_full <= EMAX) begin
            res_exp  = EXP_W'(e_full);
            res_mant = (f_reg == '0) ? '0 : MANT_W'((1 << MANT_W) - int'(f_reg));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_last  <= 1'b0;
            load_idx  <= '0;
            sum_idx   <= '0;
            emit_idx  <= '0;
            max_val   <= '0;
            sum       <= '0;
            k_reg     <= '0;
            f_reg     <= '0;
            for (int i = 0; i < N; i++) buffer[i] <= '0;
`ifdef SOFTMAX_ARGMAX_EN
            max_idx        <= '0;
            out_argmax     <= '0;
            out_argmax_hit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_valid && in_ready) begin
                        buffer[load_idx] <= in_data;
                        // Strict compare so ties keep the first occurrence.
                        if (state == IDLE || in_data > max_val) begin
                            max_val <= in_data;
`ifdef SOFTMAX_ARGMAX_EN
                            max_idx <= load_idx;
`endif
                        end
                        if (load_idx == IW'(N - 1)) begin
                            load_idx <= '0;
                            in_ready <= 1'b0;
                            state    <= SUM;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                SUM: begin
                    sum <= sum + term(max_val - buffer[sum_idx]);
                    if (sum_idx == IW'(N - 1)) begin
                        sum_idx <= '0;
                        state   <= NORM;
                    end else begin
                        sum_idx <= sum_idx + 1'b1;
                    end
                end
                NORM: begin
                    k_reg <= lod_pos - PW'(FRAC);
                    f_reg <= lod_below;
                    state <= EMIT;
`ifdef SOFTMAX_ARGMAX_EN
                    out_argmax <= max_idx;
`endif
                end
                EMIT: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_exp   <= '0;
                            out_mant  <= '0;
                            emit_idx  <= '0;
                            sum       <= '0;
                            max_val   <= '0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
`ifdef SOFTMAX_ARGMAX_EN
                            out_argmax_hit <= 1'b0;
`endif
                        end else begin
                            out_valid <= 1'b1;
                            out_exp   <= res_exp;
                            out_mant  <= res_mant;
                            out_last  <= (emit_idx == IW'(N - 1));
                            emit_idx  <= emit_idx + 1'b1;
`ifdef SOFTMAX_ARGMAX_EN
                            out_argmax_hit <= (emit_idx == max_idx);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
